mac_rr_scheduler: RTL and testbench

- Shares one pipelined multiply-accumulate datapath (A*B + C) among NUM_REQ requesters.
- Each requester presents an operand triple with a valid/ready handshake.
- A round-robin arbiter grants at most one request per cycle; results come out tagged with the requester index.
- Sits between the operand producers and the single MAC unit, so one multiplier serves all channels.

---
 rtl/mac_rr_scheduler_pkg.sv | 16 +
 rtl/mac_rr_scheduler_mac_pipe.sv | 72 +++++++
 rtl/mac_rr_scheduler.sv | 79 +++++++
 tb/tb_mac_rr_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_rr_scheduler_pkg.sv
// Shared widths, requester count and small helpers for the round-robin MAC scheduler.
package mac_rr_scheduler_pkg;

  localparam int input_size  = 8;
  localparam int output_size = 16;
  localparam int NUM_REQ     = 4;
  localparam int ID_W        = $clog2(NUM_REQ);

  typedef logic [ID_W-1:0] req_id_t;

  // Reduce an arbitrary requester index modulo NUM_REQ into a tag.
  function automatic req_id_t wrap_id(input int unsigned idx);
    return req_id_t'(idx % NUM_REQ);
  endfunction

endpackage

// File: rtl/mac_rr_scheduler_mac_pipe.sv
// Two-stage A*B+C pipeline: stage 1 multiplies, stage 2 adds and truncates.
// Valid and requester tag travel alongside the data; en freezes both stages.
module mac_pipe
  import mac_rr_scheduler_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [ID_W-1:0]        in_id,
  input  logic [input_size-1:0]  a,
  input  logic [input_size-1:0]  b,
  input  logic [input_size-1:0]  c,
  output logic                   out_valid,
  output logic [ID_W-1:0]        out_id,
  output logic [output_size-1:0] out_data,
  output logic                   busy
);

  localparam int PROD_W = 2 * input_size;
  localparam int SUM_W  = ((PROD_W > output_size) ? PROD_W : output_size) + 1;

  logic              r_s1_valid;
  logic [PROD_W-1:0] r_s1_prod;
  logic [PROD_W-1:0] r_s1_c;
  req_id_t           r_s1_id;

  logic                   r_s2_valid;
  logic [output_size-1:0] r_s2_sum;
  req_id_t                r_s2_id;

  logic [SUM_W-1:0] w_sum;

  // Full-width sum before truncation to the result width.
  assign w_sum = SUM_W'(r_s1_prod) + SUM_W'(r_s1_c);

  // Stage 1: register the full product and the zero-extended addend.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset as well as the valids, because the
    // result bus must read zero out of reset; only non-blocking assignments here.
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_prod  <= '0;
      r_s1_c     <= '0;
      r_s1_id    <= '0;
    end else if (en) begin
      r_s1_valid <= in_valid;
      r_s1_prod  <= PROD_W'(a) * PROD_W'(b);
      r_s1_c     <= PROD_W'(c);
      r_s1_id    <= in_id;
    end
  end

  // Stage 2: add and wrap modulo 2^output_size; this is the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_id    <= '0;
    end else if (en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_sum   <= w_sum[output_size-1:0];
      r_s2_id    <= r_s1_id;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_sum;
  assign out_id    = r_s2_id;
  assign busy      = r_s1_valid | r_s2_valid;

endmodule

// File: rtl/mac_rr_scheduler.sv
// Round-robin front end sharing one pipelined MAC among NUM_REQ requesters.
// Holds the arbiter, the rotating priority pointer and the pipeline-advance logic.
module mac_rr_scheduler
  import mac_rr_scheduler_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*input_size-1:0] req_a,
  input  logic [NUM_REQ*input_size-1:0] req_b,
  input  logic [NUM_REQ*input_size-1:0] req_c,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [output_size-1:0]        res_data,
  output logic [ID_W-1:0]               res_id,
  output logic                          busy
);

  req_id_t r_ptr;

  logic                  w_adv;
  logic                  w_found;
  logic                  w_xfer;
  req_id_t               w_grant;
  logic [input_size-1:0] w_a;
  logic [input_size-1:0] w_b;
  logic [input_size-1:0] w_c;

  // The pipeline moves only when the output slot is empty or being drained.
  assign w_adv = !res_valid || res_ready;

  // Search req_valid from r_ptr upward, wrapping, for the first requester.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the loop can leave it unassigned and infer a latch.
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      automatic req_id_t idx = wrap_id(int'(r_ptr) + k);
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_grant = idx;
      end
    end
  end

  assign req_ready = (rst_n && w_found && w_adv) ? (NUM_REQ'(1) << w_grant) : '0;
  assign w_xfer    = |(req_valid & req_ready);

  assign w_a = req_a[w_grant*input_size +: input_size];
  assign w_b = req_b[w_grant*input_size +: input_size];
  assign w_c = req_c[w_grant*input_size +: input_size];

  // Priority rotates to just past the winner after each accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= wrap_id(int'(w_grant) + 1);
    end
  end

  mac_pipe u_mac_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (w_adv),
    .in_valid (w_xfer),
    .in_id    (w_grant),
    .a        (w_a),
    .b        (w_b),
    .c        (w_c),
    .out_valid(res_valid),
    .out_id   (res_id),
    .out_data (res_data),
    .busy     (busy)
  );

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// Directed bench for mac_rr_scheduler: queued requesters, a cycle-level
// reference model compared every cycle, and literal expectations per scenario.
module tb_mac_rr_scheduler;
  import mac_rr_scheduler_pkg::*;

  localparam int N = NUM_REQ;
  localparam int W = input_size;
  localparam int QD = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N-1:0]           req_valid = '0;
  logic [N-1:0]           req_ready;
  logic [N*W-1:0]         req_a = '0;
  logic [N*W-1:0]         req_b = '0;
  logic [N*W-1:0]         req_c = '0;
  logic                   res_valid;
  logic                   res_ready = 1'b1;
  logic [output_size-1:0] res_data;
  logic [ID_W-1:0]        res_id;
  logic                   busy;

  mac_rr_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_c    (req_c),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_id   (res_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-requester operand queues; the driver presents the head until accepted.
  logic [W-1:0] op_a [N][QD];
  logic [W-1:0] op_b [N][QD];
  logic [W-1:0] op_c [N][QD];
  int head [N];
  int tail [N];
  logic [N-1:0] acc = '0;

  task automatic enq(input int i, input int a, input int b, input int c);
    op_a[i][tail[i]] = W'(a);
    op_b[i][tail[i]] = W'(b);
    op_c[i][tail[i]] = W'(c);
    tail[i]++;
  endtask

  // Logs of what the DUT actually did, for literal per-scenario checks.
  int got_d[$];
  int got_id[$];
  int got_cyc[$];
  int gnt_id[$];
  int gnt_cyc[$];
  int cyc = 0;

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clear_logs();
    got_d.delete(); got_id.delete(); got_cyc.delete();
    gnt_id.delete(); gnt_cyc.delete();
  endtask

  // Requester driver: pop an accepted op, then present the next one.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) head[i]++;
        if (head[i] < tail[i]) begin
          req_valid[i]     = 1'b1;
          req_a[i*W +: W]  = op_a[i][head[i]];
          req_b[i*W +: W]  = op_b[i][head[i]];
          req_c[i*W +: W]  = op_c[i][head[i]];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Reference model: operations in flight as two delay slots; the result is
  // computed whole at acceptance time and simply carried to the output.
  typedef struct packed {
    logic        v;
    logic [15:0] d;
    logic [7:0]  id;
  } slot_t;

  initial begin
    slot_t m1, m2;
    int    m_ptr, g, idx, va, vb, vc;
    logic  adv, prev_stall;
    logic [N-1:0] exp_ready;
    logic [output_size-1:0] prev_d;
    logic [ID_W-1:0] prev_id;
    m1 = '0; m2 = '0; m_ptr = 0; prev_stall = 1'b0; prev_d = '0; prev_id = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_res_data", 32'(res_data), 0);
        check("rst_res_id", 32'(res_id), 0);
        m1 = '0; m2 = '0; m_ptr = 0; acc = '0; prev_stall = 1'b0;
      end else begin
        adv = !m2.v || res_ready;
        g = -1;
        if (adv) begin
          for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
          end
        end
        exp_ready = (g >= 0) ? (N'(1) << g) : '0;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("res_valid", 32'(res_valid), 32'(m2.v));
        if (m2.v) begin
          check("res_data", 32'(res_data), 32'(m2.d));
          check("res_id", 32'(res_id), 32'(m2.id));
        end
        check("busy", 32'(busy), 32'(m1.v | m2.v));
        if (prev_stall) begin
          check("stall_hold_data", 32'(res_data), 32'(prev_d));
          check("stall_hold_id", 32'(res_id), 32'(prev_id));
        end
        prev_stall = res_valid && !res_ready;
        prev_d = res_data;
        prev_id = res_id;
        if (res_valid && res_ready) begin
          got_d.push_back(int'(res_data));
          got_id.push_back(int'(res_id));
          got_cyc.push_back(cyc);
        end
        acc = req_valid & req_ready;
        for (int i = 0; i < N; i++) begin
          if (acc[i]) begin
            gnt_id.push_back(i);
            gnt_cyc.push_back(cyc);
          end
        end
        if (adv) begin
          m2 = m1;
          if (g >= 0) begin
            va = int'(req_a[g*W +: W]);
            vb = int'(req_b[g*W +: W]);
            vc = int'(req_c[g*W +: W]);
            m1.v  = 1'b1;
            m1.d  = 16'((va * vb + vc) % 65536);
            m1.id = 8'(g);
            m_ptr = (g + 1) % N;
          end else begin
            m1 = '0;
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    clear_logs();
  endtask

  initial begin
    int rep0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Single request: 3*4+5 = 17 from requester 0, two cycles after grant.
    clear_logs();
    @(posedge clk); #2;
    enq(0, 3, 4, 5);
    repeat (8) @(posedge clk);
    check("single_count", 32'(got_d.size()), 1);
    check("single_data", 32'(qget(got_d, 0)), 17);
    check("single_id", 32'(qget(got_id, 0)), 0);
    check("single_grants", 32'(gnt_id.size()), 1);
    check("single_latency", 32'(qget(got_cyc, 0) - qget(gnt_cyc, 0)), 2);

    // All four at once: results 2,5,8,11 back to back, ids 0..3.
    do_reset();
    @(posedge clk); #2;
    for (int i = 0; i < N; i++) enq(i, i + 1, 2, i);
    repeat (12) @(posedge clk);
    check("all_count", 32'(got_d.size()), 4);
    for (int i = 0; i < 4; i++) begin
      check("all_data", 32'(qget(got_d, i)), 32'(3 * i + 2));
      check("all_id", 32'(qget(got_id, i)), 32'(i));
    end
    check("all_no_gaps", 32'(qget(got_cyc, 3) - qget(got_cyc, 0)), 3);

    // Fairness: requesters 0 and 2 both kept busy must alternate.
    do_reset();
    @(posedge clk); #2;
    for (int k = 0; k < 5; k++) begin
      enq(0, 10 + k, 3, k);
      enq(2, k + 1, 7, 1);
    end
    repeat (16) @(posedge clk);
    check("fair_grants", 32'(gnt_id.size()), 10);
    for (int j = 0; j < 8; j++) check("fair_order", 32'(qget(gnt_id, j)), (j % 2 == 0) ? 0 : 2);
    rep0 = 0;
    for (int j = 1; j < gnt_id.size(); j++) if (gnt_id[j] == 0 && gnt_id[j-1] == 0) rep0++;
    check("fair_no_repeat0", 32'(rep0), 0);
    check("fair_first_data", 32'(qget(got_d, 0)), 30);
    check("fair_second_data", 32'(qget(got_d, 1)), 8);

    // Backpressure: stall 3 cycles after the first result; all four arrive once, in order.
    do_reset();
    @(posedge clk); #2;
    for (int i = 0; i < N; i++) enq(i, i + 5, i + 2, 3 * i);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    check("bp_first_seen", 32'(res_valid), 1);
    @(posedge clk); #2;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    res_ready = 1'b1;
    repeat (12) @(posedge clk);
    check("bp_count", 32'(got_d.size()), 4);
    check("bp_d0", 32'(qget(got_d, 0)), 10);
    check("bp_d1", 32'(qget(got_d, 1)), 21);
    check("bp_d2", 32'(qget(got_d, 2)), 34);
    check("bp_d3", 32'(qget(got_d, 3)), 49);
    for (int i = 0; i < 4; i++) check("bp_id", 32'(qget(got_id, i)), 32'(i));
    check("bp_grants", 32'(gnt_id.size()), 4);

    // Max operands: 255*255+255 = 65280 fits in 16 bits.
    do_reset();
    @(posedge clk); #2;
    enq(2, 255, 255, 255);
    repeat (8) @(posedge clk);
    check("max_count", 32'(got_d.size()), 1);
    check("max_data", 32'(qget(got_d, 0)), 65280);
    check("max_id", 32'(qget(got_id, 0)), 2);

    // Reset mid-operation: two ops in flight are discarded.
    do_reset();
    @(posedge clk); #2;
    enq(0, 1, 1, 1);
    enq(1, 2, 2, 2);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (gnt_id.size() >= 2) break;
    end
    check("mid_grants", 32'(gnt_id.size()), 2);
    @(posedge clk); #2;
    check("mid_busy_before", 32'(busy), 1);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    #1;
    check("mid_res_valid_drop", 32'(res_valid), 0);
    check("mid_busy_drop", 32'(busy), 0);
    check("mid_ready_drop", 32'(req_ready), 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    clear_logs();
    repeat (4) @(posedge clk);
    check("mid_no_stale", 32'(got_d.size()), 0);
    #2;
    for (int i = 0; i < N; i++) enq(i, i, 1, 0);
    repeat (12) @(posedge clk);
    check("mid_first_grant", 32'(qget(gnt_id, 0)), 0);
    check("mid_after_count", 32'(got_d.size()), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
